bm_functional_seq: RTL

- Parametrised successor to the 8-bit functional micro-benchmark: a start-triggered sequencer that steps an op counter through a fixed table of arithmetic/logic operations on registered operands.
- Adds operand-width and counter-width generics, start/enable handshake, per-result valid strobe, done pulse at wrap, and a running XOR checksum.
- Sits in the ODIN_II micro regression set as a synthesis and simulation stress block for mult/add/sub/mux inference.

---
 rtl/bm_functional_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bm_functional_seq.sv
// bm_functional_seq: start-triggered sequencer stepping a counter through a fixed op table.
// Latency: one cycle from operand sample to registered out0/out_valid/out1/checksum.
// Backpressure: enable=0 in RUN freezes the sequence; no result is emitted while stalled.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   start                   begin a sequence (honoured only in IDLE)
//   enable                  advance one step per cycle while high in RUN
//   a_in, b_in, c_in, d_in  WIDTH-bit operands
//   out0                    registered 2*WIDTH op result
//   out1                    window flag (executed step index < WINDOW)
//   out_valid               out0/out1 updated this cycle
//   counter                 index of the next step to execute
//   checksum                XOR of all valid out0 values since start
//   done                    one-cycle pulse on the final step of a sequence
//   busy                    high while in RUN
//
// Build option: BM_FUNC_SAT_SUB_EN makes ops 5 and 8 saturating unsigned subtracts.
module bm_functional_seq #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [WIDTH-1:0]     c_in,
  input  logic [WIDTH-1:0]     d_in,
  output logic [2*WIDTH-1:0]   out0,
  output logic                 out1,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     counter,
  output logic [2*WIDTH-1:0]   checksum,
  output logic                 done,
  output logic                 busy
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   out0_q, out0_d;
  logic            out1_q, out1_d;
  logic            valid_q, valid_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [W2-1:0]   checksum_q, checksum_d;
  logic            done_q, done_d;

  // Operands zero-extended to result width so every op is evaluated mod 2**W2.
  logic [W2-1:0] a_x, b_x, c_x, d_x;
  logic [W2-1:0] ab_sub, cd_sub, cd_mul, cd_add;
  logic [W2-1:0] op_res;
  logic          in_window;
  logic          last_step;

  assign a_x = W2'(a_in);
  assign b_x = W2'(b_in);
  assign c_x = W2'(c_in);
  assign d_x = W2'(d_in);

  // Full WIDTH x WIDTH product always fits in W2 bits, so no overflow here.
  assign cd_mul = c_x * d_x;
  assign cd_add = c_x + d_x;

`ifdef BM_FUNC_SAT_SUB_EN
  assign ab_sub = (a_x < b_x) ? '0 : (a_x - b_x);
  assign cd_sub = (c_x < d_x) ? '0 : (c_x - d_x);
`else
  assign ab_sub = a_x - b_x;
  assign cd_sub = c_x - d_x;
`endif

  // Widen the counter so the case labels and window compare are width-safe for any CNT_W.
  assign in_window = (32'(counter_q) < 32'(WINDOW));
  assign last_step = (counter_q == '1);

  always_comb begin
    op_res = W2'(8'hCD);
    case (32'(counter_q))
      32'd0:   op_res = a_x & b_x;
      32'd1:   op_res = a_x | b_x;
      32'd2:   op_res = a_x ^ b_x;
      32'd3:   op_res = a_x * b_x;
      32'd4:   op_res = a_x + b_x;
      32'd5:   op_res = ab_sub;
      32'd6:   op_res = cd_mul;
      32'd7:   op_res = cd_add;
      32'd8:   op_res = cd_sub;
      32'd9:   op_res = (~c_x) & d_x;
      32'd10:  op_res = (cd_mul != '0) ? cd_add : cd_sub;
      default: op_res = W2'(8'hCD);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    counter_d  = counter_q;
    checksum_d = checksum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          counter_d  = '0;
          checksum_d = '0;
        end
      end
      ST_RUN: begin
        if (enable) begin
          out0_d     = op_res;
          out1_d     = in_window;
          valid_d    = 1'b1;
          checksum_d = checksum_q ^ op_res;
          if (last_step) begin
            // Returning to IDLE here means a start on this same edge is not seen.
            counter_d = '0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      out0_q     <= '0;
      out1_q     <= 1'b0;
      valid_q    <= 1'b0;
      counter_q  <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      valid_q    <= valid_d;
      counter_q  <= counter_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = valid_q;
  assign counter   = counter_q;
  assign checksum  = checksum_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_RUN);

endmodule
